// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the Simple_CPU control path.
//   opcode_t  - instruction opcode held in IR[7:4]
//   ALU_*     - ALU operation selects, matching the ALU's own encoding
//   state_t   - sequencer states
//   DST_*, WB_*, ADDR_* - register-file target, write-back source, address source
//   ctrl_t    - bundle of every control output driven by the sequencer
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP, OP_MOVAB, OP_MOVBA, OP_INC,
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_SHR, OP_SHL, OP_LD, OP_ST,
        OP_JMP, OP_JC, OP_JZ, OP_HLT
    } opcode_t;

    localparam logic [3:0] ALU_SELA = 4'b0000;
    localparam logic [3:0] ALU_SELB = 4'b0001;
    localparam logic [3:0] ALU_INC  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0111;
    localparam logic [3:0] ALU_SHR  = 4'b1000;
    localparam logic [3:0] ALU_SHL  = 4'b1001;

    typedef enum logic [2:0] {
        S_FETCH, S_LOADIR, S_EXEC, S_MEMRD, S_JUMP, S_HALT
    } state_t;

    localparam logic DST_A   = 1'b0;
    localparam logic DST_B   = 1'b1;
    localparam logic WB_ALU  = 1'b0;
    localparam logic WB_MEM  = 1'b1;
    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_B  = 1'b1;

    typedef struct packed {
        logic [3:0] alu_sel;
        logic       write_cz;
        logic       reg_write;
        logic       reg_dst;
        logic       wb_sel;
        logic       mem_read;
        logic       mem_write;
        logic       addr_sel;
        logic       pc_inc;
        logic       pc_load;
        logic       halt;
    } ctrl_t;

    // ALU select for the flag-writing arithmetic/logic opcodes.
    function automatic logic [3:0] alu_sel_of(input opcode_t op);
        case (op)
            OP_INC:  return ALU_INC;
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            default: return ALU_SELA;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational map from sequencer state and opcode to controls.
//   state      - current sequencer state
//   opcode     - IR[7:4]
//   cf, zf     - ALU flags, used only to resolve conditional jumps
//   ctrl       - control output bundle
//   next_state - state to enter at the next clock edge
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t  state,
    input  opcode_t opcode,
    input  logic    cf,
    input  logic    zf,
    output ctrl_t   ctrl,
    output state_t  next_state
);

    always_comb begin
        ctrl       = '0;
        next_state = state;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.addr_sel = ADDR_PC;
                ctrl.pc_inc   = 1'b1;
                next_state    = S_LOADIR;
            end
            S_LOADIR: next_state = S_EXEC;
            S_EXEC: begin
                next_state = S_FETCH;
                case (opcode)
                    OP_NOP: ;
                    OP_MOVAB: begin
                        ctrl.alu_sel   = ALU_SELB;
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_dst   = DST_A;
                    end
                    OP_MOVBA: begin
                        ctrl.alu_sel   = ALU_SELA;
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_dst   = DST_B;
                    end
                    OP_INC, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
                        ctrl.alu_sel   = alu_sel_of(opcode);
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_dst   = DST_A;
                        ctrl.write_cz  = 1'b1;
                    end
                    OP_LD: begin
                        ctrl.mem_read = 1'b1;
                        ctrl.addr_sel = ADDR_B;
                        next_state    = S_MEMRD;
                    end
                    OP_ST: begin
                        ctrl.mem_write = 1'b1;
                        ctrl.addr_sel  = ADDR_B;
                    end
                    // The target byte is read and skipped here whether or not the jump is taken.
                    OP_JMP, OP_JC, OP_JZ: begin
                        ctrl.mem_read = 1'b1;
                        ctrl.addr_sel = ADDR_PC;
                        ctrl.pc_inc   = 1'b1;
                        next_state    = S_JUMP;
                    end
                    OP_HLT: next_state = S_HALT;
                endcase
            end
            S_MEMRD: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = DST_A;
                ctrl.wb_sel    = WB_MEM;
                next_state     = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_load = (opcode == OP_JMP) | ((opcode == OP_JC) & cf) | ((opcode == OP_JZ) & zf);
                next_state   = S_FETCH;
            end
            S_HALT: ctrl.halt = 1'b1;
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer for the Simple_CPU datapath.
//   Clk, Reset        - clock and synchronous active-high reset
//   MemData           - memory read data, valid the cycle after MemRead
//   CF, ZF            - ALU flags
//   ALUSel, WriteCZ   - ALU operation select and flag-update enable
//   RegWrite, RegDst, WBSel - register-file write controls
//   MemRead, MemWrite, AddrSel - memory strobes and address source
//   PCInc, PCLoad     - program-counter controls (PCLoad wins)
//   Halt              - high while halted
module control_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH_DATA_LENGTH   = 8,
    parameter int WIDTH_ALUSEL_LENGTH = 4
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [WIDTH_DATA_LENGTH-1:0]   MemData,
    input  logic                           CF,
    input  logic                           ZF,
    output logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
    output logic                           WriteCZ,
    output logic                           RegWrite,
    output logic                           RegDst,
    output logic                           WBSel,
    output logic                           MemRead,
    output logic                           MemWrite,
    output logic                           AddrSel,
    output logic                           PCInc,
    output logic                           PCLoad,
    output logic                           Halt
);

    state_t                         state_q, state_d;
    logic [WIDTH_DATA_LENGTH-1:0]   ir_q, ir_d;
    opcode_t                        opcode;
    ctrl_t                          ctrl, ctrl_o;
    logic                           unused_ir_lo;

    assign opcode       = opcode_t'(ir_q[WIDTH_DATA_LENGTH-1 -: 4]);
    assign unused_ir_lo = ^ir_q[WIDTH_DATA_LENGTH-5:0];

    ctrl_decode u_decode (
        .state      (state_q),
        .opcode     (opcode),
        .cf         (CF),
        .zf         (ZF),
        .ctrl       (ctrl),
        .next_state (state_d)
    );

    always_comb begin
        ir_d   = (state_q == S_LOADIR) ? MemData : ir_q;
        // Gating during reset keeps an aborted instruction from writing anything.
        ctrl_o = Reset ? '0 : ctrl;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign ALUSel   = WIDTH_ALUSEL_LENGTH'(ctrl_o.alu_sel);
    assign WriteCZ  = ctrl_o.write_cz;
    assign RegWrite = ctrl_o.reg_write;
    assign RegDst   = ctrl_o.reg_dst;
    assign WBSel    = ctrl_o.wb_sel;
    assign MemRead  = ctrl_o.mem_read;
    assign MemWrite = ctrl_o.mem_write;
    assign AddrSel  = ctrl_o.addr_sel;
    assign PCInc    = ctrl_o.pc_inc;
    assign PCLoad   = ctrl_o.pc_load;
    assign Halt     = ctrl_o.halt;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: self-checking bench expanding each instruction into its expected per-cycle control trace.
module tb_control_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] MemData = '0;
    logic       CF = 1'b0;
    logic       ZF = 1'b0;
    logic [3:0] ALUSel;
    logic       WriteCZ, RegWrite, RegDst, WBSel, MemRead, MemWrite, AddrSel, PCInc, PCLoad, Halt;
    logic [13:0] obs;
    int         checks = 0;
    int         errors = 0;

    localparam logic [13:0] B_WCZ = 14'h200;
    localparam logic [13:0] B_RW  = 14'h100;
    localparam logic [13:0] B_RD  = 14'h080;
    localparam logic [13:0] B_WB  = 14'h040;
    localparam logic [13:0] B_MR  = 14'h020;
    localparam logic [13:0] B_MW  = 14'h010;
    localparam logic [13:0] B_AS  = 14'h008;
    localparam logic [13:0] B_PI  = 14'h004;
    localparam logic [13:0] B_PL  = 14'h002;
    localparam logic [13:0] B_H   = 14'h001;

    control_unit dut (
        .Clk(Clk), .Reset(Reset), .MemData(MemData), .CF(CF), .ZF(ZF),
        .ALUSel(ALUSel), .WriteCZ(WriteCZ), .RegWrite(RegWrite), .RegDst(RegDst),
        .WBSel(WBSel), .MemRead(MemRead), .MemWrite(MemWrite), .AddrSel(AddrSel),
        .PCInc(PCInc), .PCLoad(PCLoad), .Halt(Halt)
    );

    always #5 Clk = ~Clk;

    assign obs = {ALUSel, WriteCZ, RegWrite, RegDst, WBSel, MemRead, MemWrite, AddrSel, PCInc, PCLoad, Halt};

    function automatic logic [13:0] alu(input logic [3:0] sel);
        return {sel, 10'b0};
    endfunction

    // Expected EXEC-cycle controls straight from the instruction table.
    function automatic logic [13:0] exec_exp(input logic [3:0] op);
        if (op == 4'h0) return '0;
        if (op == 4'h1) return alu(4'd1) | B_RW;
        if (op == 4'h2) return alu(4'd0) | B_RW | B_RD;
        if (op == 4'h3) return alu(4'd2) | B_RW | B_WCZ;
        if (op <= 4'h9) return alu(op) | B_RW | B_WCZ;
        if (op == 4'hA) return B_MR | B_AS;
        if (op == 4'hB) return B_MW | B_AS;
        if (op <= 4'hE) return B_MR | B_PI;
        return '0;
    endfunction

    task automatic cyc(input logic r, input logic [7:0] md, input logic cf, input logic zf,
                       input logic [13:0] exp, input string tag);
        @(negedge Clk);
        Reset = r; MemData = md; CF = cf; ZF = zf;
        #1;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full instruction from FETCH; the next instruction's FETCH check confirms the cycle count.
    task automatic run_instr(input logic [7:0] ins, input logic cf, input logic zf);
        logic [3:0] op;
        logic       taken;
        op = ins[7:4];
        cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), B_MR | B_PI, "fetch");
        cyc(1'b0, ins, 1'($urandom), 1'($urandom), '0, "loadir");
        cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), exec_exp(op), "exec");
        if (op == 4'hA)
            cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), B_RW | B_WB, "memrd");
        if (op >= 4'hC && op <= 4'hE) begin
            taken = (op == 4'hC) || (op == 4'hD && cf) || (op == 4'hE && zf);
            cyc(1'b0, 8'h3C, cf, zf, taken ? B_PL : '0, "jump");
        end
    endtask

    initial begin
        cyc(1'b1, 8'h00, 1'b0, 1'b0, '0, "reset0");
        cyc(1'b1, 8'h40, 1'b1, 1'b1, '0, "reset1");
        run_instr(8'h40, 1'b0, 1'b0);
        run_instr(8'hA0, 1'b0, 1'b0);
        run_instr(8'hE0, 1'b0, 1'b1);
        run_instr(8'hE0, 1'b1, 1'b0);
        run_instr(8'h10, 1'b0, 1'b0);
        run_instr(8'hD0, 1'b1, 1'b0);
        run_instr(8'hD0, 1'b0, 1'b1);
        run_instr(8'hC7, 1'b0, 1'b0);
        run_instr(8'h2F, 1'b0, 1'b0);
        run_instr(8'hB0, 1'b0, 1'b0);
        repeat (200) begin
            logic [7:0] ins;
            ins = {4'($urandom_range(0, 14)), 4'($urandom)};
            run_instr(ins, 1'($urandom), 1'($urandom));
        end
        run_instr(8'hF0, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), B_H, "halt");
        cyc(1'b1, 8'h00, 1'b0, 1'b0, '0, "halt_reset");
        cyc(1'b0, 8'($urandom), 1'b0, 1'b0, B_MR | B_PI, "fetch_after_halt");
        cyc(1'b0, 8'hB0, 1'b0, 1'b0, '0, "st_loadir");
        cyc(1'b1, 8'h00, 1'b0, 1'b0, '0, "st_exec_reset");
        run_instr(8'h30, 1'b0, 1'b0);
        run_instr(8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, B_MR | B_PI, "final_fetch");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle instruction sequencer for the Simple_CPU 8-bit datapath.
- Fetches one-byte instructions from synchronous memory and holds them in an internal IR.
- Drives the ALU select and flag-write controls, and consumes the ALU's CF/ZF flags.
- Also drives register-file, memory and PC controls; it is the control end of the ALU interface.

Parameters:
- WIDTH_DATA_LENGTH, 8, width of instruction/data bus and IR.
- WIDTH_ALUSEL_LENGTH, 4, width of ALUSel output.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- MemData  input  WIDTH_DATA_LENGTH  memory read data, valid the cycle after MemRead.
- CF  input  1  ALU carry flag.
- ZF  input  1  ALU zero flag.
- ALUSel  output  WIDTH_ALUSEL_LENGTH  ALU operation select.
- WriteCZ  output  1  ALU flag-update enable.
- RegWrite  output  1  register-file write enable.
- RegDst  output  1  write target: 0=A, 1=B.
- WBSel  output  1  write-back source: 0=ALU DataOut, 1=MemData.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe (data=A).
- AddrSel  output  1  memory address: 0=PC, 1=B.
- PCInc  output  1  PC <= PC+1 at next edge.
- PCLoad  output  1  PC <= MemData at next edge; has priority over PCInc.
- Halt  output  1  high while in HALT.

Behaviour:
- Synchronous active-high reset: one clock; reset is synchronous and active-high, on Clk/Reset.
  - Reset sampled high: state <= FETCH, IR <= 8'h00.
  - While Reset is high, all outputs are forced to 0.
  - Reset mid-instruction aborts it; no partial write is completed after the reset edge.
- Default for all outputs in any state/opcode not listed below: 0 (ALUSel = 4'b0000).
- Opcode = IR[7:4]; IR[3:0] is ignored.
- States:
  - FETCH: MemRead=1, AddrSel=0, PCInc=1 -> LOADIR.
  - LOADIR: IR <= MemData -> EXEC.
  - EXEC, decoded by opcode:
    - 0x0 NOP: no outputs -> FETCH.
    - 0x1 MOV A,B: ALUSel=0001, RegWrite, RegDst=0 -> FETCH.
    - 0x2 MOV B,A: ALUSel=0000, RegWrite, RegDst=1 -> FETCH.
    - 0x3 INC A: ALUSel=0010, RegWrite, RegDst=0, WriteCZ -> FETCH.
    - 0x4..0x9 ADD/SUB/AND/OR/SHR/SHL: ALUSel=0100..1001 respectively, RegWrite, RegDst=0, WriteCZ -> FETCH.
    - 0xA LD A,[B]: MemRead, AddrSel=1 -> MEMRD.
    - 0xB ST [B],A: MemWrite, AddrSel=1 -> FETCH.
    - 0xC JMP / 0xD JC / 0xE JZ: MemRead, AddrSel=0, PCInc (consumes target byte) -> JUMP.
    - 0xF HLT -> HALT.
  - MEMRD: RegWrite, RegDst=0, WBSel=1 -> FETCH.
  - JUMP:
    - taken = JMP | (JC & CF) | (JZ & ZF), with CF/ZF sampled this cycle.
    - PCLoad = taken; untaken leaves PC pointing past the operand -> FETCH.
  - HALT: Halt=1, all other outputs 0, no state exit except Reset.
- Cycle counts, FETCH to next FETCH:
  - NOP, MOV, ALU, ST: 3 cycles.
  - LD, JMP, JC, JZ: 4 cycles.
- MOV and NOP never assert WriteCZ, so flags persist across them into a following JC/JZ.
- All 16 opcodes are defined; there is no illegal-opcode trap.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode enum (OP_NOP..OP_HLT);
  - the ALUSel constants (ALU_SELA..ALU_SHL, matching the ALU encoding);
  - the state enum (S_FETCH, S_LOADIR, S_EXEC, S_MEMRD, S_JUMP, S_HALT);
  - the RegDst, WBSel and AddrSel encodings.
- One combinational sub-module, ctrl_decode, maps (state, opcode, CF, ZF) to the output bundle and next state.
- control_unit keeps the state and IR registers and the reset gating.

Test Plan:
- Reset high 2 cycles, then low -> next cycle MemRead=1, AddrSel=0, PCInc=1; all outputs 0 during reset.
- MemData=8'h40 (ADD) at LOADIR -> EXEC: ALUSel=4'b0100, WriteCZ=1, RegWrite=1, RegDst=0; FETCH again 3 cycles after the prior FETCH.
- MemData=8'hA0 (LD) -> EXEC: MemRead=1, AddrSel=1; MEMRD: RegWrite=1, WBSel=1, RegDst=0; 4-cycle instruction.
- JZ (8'hE0) with ZF=1, target byte 8'h3C -> JUMP: PCLoad=1; repeat with ZF=0 -> PCLoad=0; PCInc asserted in EXEC in both cases.
- JC with CF=1, preceded by MOV A,B -> WriteCZ=0 during MOV, PCLoad=1 in JUMP.
- HLT (8'hF0) -> Halt=1 held for 20 cycles with MemRead=0; Reset asserted during ST's EXEC -> MemWrite=0 that cycle, FETCH resumes after reset is released.
